hit_judge: RTL and testbench

- Rhythm-game judge stage, directly downstream of the note shift/load block.
- Takes player button presses and the judge-column note flags plus pixel offset from the shift stage.
- Grades each note as perfect, good or miss, pulses `delete` back to the shift stage on a correct hit, and keeps score, hit and miss counters for the display logic.

---
 rtl/hit_judge.sv | 152 +++++++++++++++
 tb/tb_hit_judge.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hit_judge.sv
// Rhythm-game judge: conditions the two buttons, grades notes in the judge column,
// and keeps saturating score/hit/miss counters for the display.
module hit_judge #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [15:0] PERFECT_POINTS  = 16'd2,
  parameter logic [15:0] GOOD_POINTS     = 16'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        red_button,
  input  logic        blue_button,
  input  logic        note_R_judge,
  input  logic        note_B_judge,
  input  logic [2:0]  offset,
  input  logic        finish,
  output logic        delete,
  output logic [15:0] score,
  output logic [7:0]  hit_cnt,
  output logic [7:0]  miss_cnt,
  output logic [1:0]  judge_result,
  output logic        result_valid
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {S_WAIT, S_NOTE, S_HELD, S_DONE} state_t;

  // Bit 0 is red, bit 1 is blue throughout.
  logic [1:0]       sync1, sync2, db, db_d;
  logic [CNT_W-1:0] db_cnt [2];
  logic [1:0]       press;

  state_t      state;
  logic        col;
  logic        note_present, cur_col;
  logic        hit_c, miss_c, perfect_c;
  logic [15:0] points_c;
  logic [16:0] sum_c;

  // Two-flop synchronizer and per-button debounce counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= '0;
      sync2  <= '0;
      db     <= '0;
      db_d   <= '0;
      db_cnt <= '{default: '0};
    end else begin
      sync1 <= {blue_button, red_button};
      sync2 <= sync1;
      db_d  <= db;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != db[i]) begin
          if (db_cnt[i] >= DEBOUNCE_CYCLES - 16'd1) begin
            db[i]     <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 16'd1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign press        = db & ~db_d;
  assign note_present = note_R_judge | note_B_judge;
  assign cur_col      = note_B_judge;
  assign perfect_c    = (offset >= 3'd2) && (offset <= 3'd4);
  assign points_c     = perfect_c ? PERFECT_POINTS : GOOD_POINTS;
  assign sum_c        = {1'b0, score} + {1'b0, points_c};

  // Grade decode; a colour change in NOTE takes precedence over any press.
  always_comb begin
    hit_c  = 1'b0;
    miss_c = 1'b0;
    if (!finish) begin
      case (state)
        S_WAIT: miss_c = |press;
        S_NOTE: begin
          if (!note_present)       miss_c = 1'b1;
          else if (cur_col != col) miss_c = 1'b1;
          else if (press[col])     hit_c  = 1'b1;
          else if (|press)         miss_c = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_WAIT;
      col          <= 1'b0;
      delete       <= 1'b0;
      score        <= '0;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
      judge_result <= '0;
      result_valid <= 1'b0;
    end else begin
      delete       <= 1'b0;
      result_valid <= 1'b0;
      if (hit_c) begin
        delete       <= 1'b1;
        result_valid <= 1'b1;
        judge_result <= perfect_c ? 2'd1 : 2'd2;
        score        <= sum_c[16] ? 16'hFFFF : sum_c[15:0];
        if (hit_cnt != 8'hFF) hit_cnt <= hit_cnt + 8'd1;
      end
      if (miss_c) begin
        result_valid <= 1'b1;
        judge_result <= 2'd3;
        if (miss_cnt != 8'hFF) miss_cnt <= miss_cnt + 8'd1;
      end
      if (finish) begin
        state <= S_DONE;
      end else begin
        case (state)
          S_WAIT: begin
            if (note_present) begin
              state <= S_NOTE;
              col   <= cur_col;
            end
          end
          S_NOTE: begin
            if (!note_present)       state <= S_WAIT;
            else if (cur_col != col) col   <= cur_col;
            else if (|press)         state <= S_HELD;
          end
          S_HELD: begin
            if (!note_present) begin
              state <= S_WAIT;
            end else if (cur_col != col) begin
              col   <= cur_col;
              state <= S_NOTE;
            end
          end
          default: begin
            state        <= S_WAIT;
            score        <= '0;
            hit_cnt      <= '0;
            miss_cnt     <= '0;
            judge_result <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge with a short debounce window.
module tb_hit_judge;

  logic        clk = 1'b0;
  logic        rst;
  logic        red, blue, note_r, note_b, finish;
  logic [2:0]  offset;
  logic        delete, result_valid;
  logic [15:0] score;
  logic [7:0]  hit_cnt, miss_cnt;
  logic [1:0]  judge_result;

  int n_checks = 0;
  int n_fail   = 0;
  int del_seen = 0;
  int rv_seen  = 0;

  hit_judge #(.DEBOUNCE_CYCLES(16'd4), .PERFECT_POINTS(16'd2), .GOOD_POINTS(16'd1)) dut (
    .clk(clk), .rst(rst), .red_button(red), .blue_button(blue),
    .note_R_judge(note_r), .note_B_judge(note_b), .offset(offset), .finish(finish),
    .delete(delete), .score(score), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
    .judge_result(judge_result), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (delete)       del_seen++;
    if (result_valid) rv_seen++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; red = 1'b0; blue = 1'b0; note_r = 1'b0; note_b = 1'b0;
    finish = 1'b0; offset = 3'd0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic hit_once(input logic [2:0] off);
    note_r = 1'b1; offset = off;
    tick();
    red = 1'b1;
    repeat (10) tick();
    red = 1'b0; note_r = 1'b0;
    repeat (10) tick();
  endtask

  task automatic stray_red();
    red = 1'b1;
    repeat (8) tick();
    red = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; red = 1'b0; blue = 1'b0; note_r = 1'b0; note_b = 1'b0;
    finish = 1'b0; offset = 3'd0;
    #3;
    n_checks++;
    if ({delete, score, hit_cnt, miss_cnt, judge_result, result_valid} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {delete, score, hit_cnt, miss_cnt, judge_result, result_valid});
    end
    do_reset();
  endtask

  task automatic test_perfect();
    int first_del, d0;
    do_reset();
    d0 = del_seen; first_del = -1;
    note_r = 1'b1; offset = 3'd3;
    tick();
    red = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (delete && first_del < 0) first_del = c;
    end
    red = 1'b0; note_r = 1'b0;
    repeat (10) tick();
    n_checks++;
    if (first_del != 7) begin n_fail++; $display("FAIL perfect_latency: got %0d expected 7", first_del); end
    n_checks++;
    if (del_seen - d0 != 1) begin n_fail++; $display("FAIL perfect_delete_width: got %0d expected 1", del_seen - d0); end
    n_checks++;
    if (judge_result !== 2'd1) begin n_fail++; $display("FAIL perfect_grade: got %0d expected 1", judge_result); end
    n_checks++;
    if (score !== 16'd2) begin n_fail++; $display("FAIL perfect_score: got %0d expected 2", score); end
    n_checks++;
    if (hit_cnt !== 8'd1) begin n_fail++; $display("FAIL perfect_hits: got %0d expected 1", hit_cnt); end
  endtask

  task automatic test_good_held();
    int d0;
    do_reset();
    d0 = del_seen;
    note_r = 1'b1; offset = 3'd6;
    tick();
    red = 1'b1; repeat (10) tick();
    red = 1'b0; repeat (10) tick();
    n_checks++;
    if (judge_result !== 2'd2) begin n_fail++; $display("FAIL good_grade: got %0d expected 2", judge_result); end
    n_checks++;
    if (score !== 16'd1) begin n_fail++; $display("FAIL good_score: got %0d expected 1", score); end
    red = 1'b1; repeat (10) tick();
    red = 1'b0; repeat (10) tick();
    note_r = 1'b0; repeat (4) tick();
    n_checks++;
    if (del_seen - d0 != 1) begin n_fail++; $display("FAIL held_delete: got %0d expected 1", del_seen - d0); end
    n_checks++;
    if ({score, hit_cnt, miss_cnt} !== {16'd1, 8'd1, 8'd0}) begin
      n_fail++;
      $display("FAIL held_counters: got score %0d hits %0d misses %0d expected 1 1 0", score, hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_unhit();
    int d0, r0;
    do_reset();
    d0 = del_seen; r0 = rv_seen;
    note_b = 1'b1; repeat (20) tick();
    note_b = 1'b0; repeat (5) tick();
    n_checks++;
    if (miss_cnt !== 8'd1) begin n_fail++; $display("FAIL unhit_miss: got %0d expected 1", miss_cnt); end
    n_checks++;
    if (judge_result !== 2'd3) begin n_fail++; $display("FAIL unhit_grade: got %0d expected 3", judge_result); end
    n_checks++;
    if (rv_seen - r0 != 1) begin n_fail++; $display("FAIL unhit_valid: got %0d expected 1", rv_seen - r0); end
    n_checks++;
    if (del_seen - d0 != 0) begin n_fail++; $display("FAIL unhit_delete: got %0d expected 0", del_seen - d0); end
  endtask

  task automatic test_wrong_colour();
    int d0;
    do_reset();
    d0 = del_seen;
    note_r = 1'b1; offset = 3'd3;
    tick();
    blue = 1'b1; repeat (10) tick();
    blue = 1'b0; repeat (10) tick();
    note_r = 1'b0; repeat (5) tick();
    n_checks++;
    if (miss_cnt !== 8'd1) begin n_fail++; $display("FAIL wrong_miss: got %0d expected 1", miss_cnt); end
    n_checks++;
    if ({hit_cnt, 8'(del_seen - d0)} !== 16'd0) begin
      n_fail++; $display("FAIL wrong_nohit: got hits %0d deletes %0d expected 0 0", hit_cnt, del_seen - d0);
    end
  endtask

  task automatic test_bounce_stray();
    int r0;
    do_reset();
    r0 = rv_seen;
    for (int i = 0; i < 12; i++) begin
      red = ~red;
      repeat (2) tick();
    end
    red = 1'b0; repeat (10) tick();
    n_checks++;
    if (rv_seen - r0 != 0 || miss_cnt !== 8'd0) begin
      n_fail++; $display("FAIL bounce_event: got valids %0d misses %0d expected 0 0", rv_seen - r0, miss_cnt);
    end
    stray_red();
    n_checks++;
    if (miss_cnt !== 8'd1 || judge_result !== 2'd3) begin
      n_fail++; $display("FAIL stray_miss: got misses %0d grade %0d expected 1 3", miss_cnt, judge_result);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 127; i++) hit_once(3'd3);
    n_checks++;
    if (score !== 16'd254) begin n_fail++; $display("FAIL preload_score: got %0d expected 254", score); end
    hit_once(3'd4);
    n_checks++;
    if (score !== 16'd256 || hit_cnt !== 8'd128) begin
      n_fail++; $display("FAIL sat_score: got score %0d hits %0d expected 256 128", score, hit_cnt);
    end
    for (int i = 0; i < 256; i++) stray_red();
    n_checks++;
    if (miss_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_miss: got %0d expected 255", miss_cnt); end
  endtask

  task automatic test_finish();
    int d0;
    do_reset();
    hit_once(3'd3);
    d0 = del_seen;
    note_r = 1'b1; offset = 3'd3;
    tick();
    red = 1'b1;
    repeat (6) tick();
    finish = 1'b1;
    repeat (4) tick();
    red = 1'b0; repeat (10) tick();
    red = 1'b1; repeat (10) tick();
    red = 1'b0; repeat (10) tick();
    n_checks++;
    if (del_seen - d0 != 0) begin n_fail++; $display("FAIL finish_delete: got %0d expected 0", del_seen - d0); end
    n_checks++;
    if (score !== 16'd2 || hit_cnt !== 8'd1 || judge_result !== 2'd1) begin
      n_fail++; $display("FAIL finish_frozen: got score %0d hits %0d grade %0d expected 2 1 1", score, hit_cnt, judge_result);
    end
    note_r = 1'b0; finish = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({score, hit_cnt, miss_cnt, judge_result} !== 34'd0) begin
      n_fail++; $display("FAIL finish_clear: got score %0d hits %0d misses %0d grade %0d expected 0", score, hit_cnt, miss_cnt, judge_result);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    note_r = 1'b1; offset = 3'd3;
    tick();
    red = 1'b1;
    repeat (7) tick();
    n_checks++;
    if (delete !== 1'b1) begin n_fail++; $display("FAIL midreset_pre: got %0d expected 1", delete); end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({delete, score, hit_cnt, miss_cnt, judge_result, result_valid} !== 36'd0) begin
      n_fail++; $display("FAIL midreset_clear: got %h expected 0",
                         {delete, score, hit_cnt, miss_cnt, judge_result, result_valid});
    end
    red = 1'b0; note_r = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    hit_once(3'd2);
    n_checks++;
    if (judge_result !== 2'd1 || score !== 16'd2 || hit_cnt !== 8'd1) begin
      n_fail++; $display("FAIL midreset_rehit: got grade %0d score %0d hits %0d expected 1 2 1", judge_result, score, hit_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_perfect();
    test_good_held();
    test_unhit();
    test_wrong_colour();
    test_bounce_stray();
    test_saturation();
    test_finish();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
